// File: rtl/jtcontra_timing_pkg.sv
// Shared video timing defaults for the Contra video path.
package jtcontra_timing_pkg;

    localparam int unsigned DEF_HTOTAL   = 384;
    localparam int unsigned DEF_HACTIVE  = 256;
    localparam int unsigned DEF_HS_START = 296;
    localparam int unsigned DEF_HS_END   = 328;

    localparam int unsigned DEF_VTOTAL   = 264;
    localparam int unsigned DEF_VB_START = 240;
    localparam int unsigned DEF_VB_END   = 16;
    localparam int unsigned DEF_VS_START = 248;
    localparam int unsigned DEF_VS_END   = 251;

    // Blank/sync levels derived from one raw H/V position.
    typedef struct packed {
        logic lhbl;
        logic lvbl;
        logic hs;
        logic vs;
    } vflags_t;

    // Half-open window test: lo <= x < hi.
    function automatic logic in_window(input int unsigned x, input int unsigned lo,
                                       input int unsigned hi);
        return (x >= lo) && (x < hi);
    endfunction

endpackage

// File: rtl/jtcontra_vtiming_cen.sv
// Pixel clock-enable divider: pxl_cen once per CEN_DIV clocks, pxl2_cen twice.
module jtcontra_vtiming_cen #(
    parameter int unsigned CEN_DIV = 8
) (
    input  logic clk,
    input  logic rstn,
    output logic pxl2_cen,
    output logic pxl_cen
);

    localparam int unsigned   CW   = $clog2(CEN_DIV);
    localparam logic [CW-1:0] LAST = CW'(CEN_DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(CEN_DIV / 2 - 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    // Next divider value, wrapping at CEN_DIV-1.
    always_comb begin
        cnt_nxt = (cnt == LAST) ? '0 : cnt + 1'b1;
    end

    // Enables are decoded from the next count so they are high exactly while
    // the divider sits at the decoded value.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt      <= '0;
            pxl_cen  <= 1'b0;
            pxl2_cen <= 1'b0;
        end else begin
            cnt      <= cnt_nxt;
            pxl_cen  <= (cnt_nxt == LAST);
            pxl2_cen <= (cnt_nxt == LAST) || (cnt_nxt == HALF);
        end
    end

endmodule

// File: rtl/jtcontra_vtiming.sv
// Contra video timing: raw H/V counters, blanking/sync, flip, raster IRQs.
module jtcontra_vtiming
    import jtcontra_timing_pkg::*;
#(
    parameter int unsigned CEN_DIV      = 8,
    parameter int unsigned W            = 9,
    parameter int unsigned HTOTAL       = DEF_HTOTAL,
    parameter int unsigned HACTIVE      = DEF_HACTIVE,
    parameter int unsigned HS_START     = DEF_HS_START,
    parameter int unsigned HS_END       = DEF_HS_END,
    parameter int unsigned VTOTAL       = DEF_VTOTAL,
    parameter int unsigned VB_START     = DEF_VB_START,
    parameter int unsigned VB_END       = DEF_VB_END,
    parameter int unsigned VS_START     = DEF_VS_START,
    parameter int unsigned VS_END       = DEF_VS_END,
    parameter int unsigned RENDER_AHEAD = 1,
    parameter int unsigned DLY          = 2
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         flip,
    input  logic [W-1:0] irq_line,
    input  logic         irq_en,
    input  logic         irq_ack,
    output logic         pxl2_cen,
    output logic         pxl_cen,
    output logic [W-1:0] hdump,
    output logic [W-1:0] vdump,
    output logic [W-1:0] vrender,
    output logic         LHBL,
    output logic         LVBL,
    output logic         HS,
    output logic         VS,
    output logic         LHBL_dly,
    output logic         LVBL_dly,
    output logic         line_irqn,
    output logic         vb_irqn
);

    localparam logic [W-1:0] H_LAST = W'(HTOTAL - 1);
    localparam logic [W-1:0] V_LAST = W'(VTOTAL - 1);
    localparam logic [W:0]   V_TOT  = (W+1)'(VTOTAL);
    localparam logic [W:0]   R_AHD  = (W+1)'(RENDER_AHEAD);

    logic [W-1:0]   h_raw;
    logic [W-1:0]   v_raw;
    logic [W-1:0]   h_nxt;
    logic [W-1:0]   v_nxt;
    logic [W-1:0]   fmask;
    logic [W:0]     vsum;
    logic [W-1:0]   vren;
    vflags_t        flags_now;
    logic           line_set;
    logic           vb_set;
    logic [DLY-1:0] lhbl_sr;
    logic [DLY-1:0] lvbl_sr;

    jtcontra_vtiming_cen #(
        .CEN_DIV (CEN_DIV)
    ) u_cen (
        .clk      (clk),
        .rstn     (rstn),
        .pxl2_cen (pxl2_cen),
        .pxl_cen  (pxl_cen)
    );

    // Counter advance, lookahead line and blank/sync decode of the raw position.
    always_comb begin
        h_nxt = (h_raw == H_LAST) ? '0 : h_raw + 1'b1;
        v_nxt = v_raw;
        if (h_raw == H_LAST) begin
            v_nxt = (v_raw == V_LAST) ? '0 : v_raw + 1'b1;
        end
        fmask = {W{flip}};
        vsum  = {1'b0, v_raw} + R_AHD;
        vren  = (vsum >= V_TOT) ? W'(vsum - V_TOT) : W'(vsum);
        flags_now.lhbl = in_window(32'(h_raw), 0, HACTIVE);
        flags_now.hs   = in_window(32'(h_raw), HS_START, HS_END);
        flags_now.lvbl = in_window(32'(v_raw), VB_END, VB_START);
        flags_now.vs   = in_window(32'(v_raw), VS_START, VS_END);
        line_set = pxl_cen && irq_en && (h_raw == '0) && (v_raw == irq_line);
        vb_set   = pxl_cen && LVBL && !flags_now.lvbl;
    end

    // All visible outputs capture the same raw position on one pxl_cen edge,
    // so they trail the raw counters by one pixel but never disagree.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            h_raw   <= '0;
            v_raw   <= '0;
            hdump   <= '0;
            vdump   <= '0;
            vrender <= '0;
            LHBL    <= 1'b0;
            LVBL    <= 1'b0;
            HS      <= 1'b0;
            VS      <= 1'b0;
        end else if (pxl_cen) begin
            h_raw   <= h_nxt;
            v_raw   <= v_nxt;
            hdump   <= h_raw ^ fmask;
            vdump   <= v_raw ^ fmask;
            vrender <= vren ^ fmask;
            LHBL    <= flags_now.lhbl;
            LVBL    <= flags_now.lvbl;
            HS      <= flags_now.hs;
            VS      <= flags_now.vs;
        end
    end

    // Blanking delay lines stepped by pxl_cen.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lhbl_sr <= '0;
            lvbl_sr <= '0;
        end else if (pxl_cen) begin
            lhbl_sr[0] <= LHBL;
            lvbl_sr[0] <= LVBL;
            for (int unsigned i = 1; i < DLY; i++) begin
                lhbl_sr[i] <= lhbl_sr[i-1];
                lvbl_sr[i] <= lvbl_sr[i-1];
            end
        end
    end

    assign LHBL_dly = lhbl_sr[DLY-1];
    assign LVBL_dly = lvbl_sr[DLY-1];

    // Interrupt requests: a set in the same clock as an ack wins.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            line_irqn <= 1'b1;
            vb_irqn   <= 1'b1;
        end else begin
            if (line_set)     line_irqn <= 1'b0;
            else if (irq_ack) line_irqn <= 1'b1;
            if (vb_set)       vb_irqn   <= 1'b0;
            else if (irq_ack) vb_irqn   <= 1'b1;
        end
    end

endmodule

// File: doc/jtcontra_vtiming.md
JTCONTRA_VTIMING -- requirements
Module: jtcontra_vtiming

Interface
REQ-001 Parameter CEN_DIV, default 8, SHALL set the number of clk cycles per pixel; it is even and at least 2.
REQ-002 Parameter W, default 9, SHALL set the width of all H/V counters and line inputs.
REQ-003 Parameters HTOTAL=384, HACTIVE=256, HS_START=296, HS_END=328 (pixels) SHALL define horizontal timing.
REQ-004 Parameters VTOTAL=264, VB_START=240, VB_END=16, VS_START=248, VS_END=251 (lines) SHALL define vertical timing.
REQ-005 Parameters RENDER_AHEAD=1 (lines) and DLY=2 (pixels) SHALL set the vrender lookahead and the blanking delay.
REQ-006 Port list, one per entry:
 clk       in   1   system clock, 48 MHz nominal
 rstn      in   1   asynchronous, active-low reset
 flip      in   1   screen flip; mirrors hdump and vdump
 irq_line  in   W   raster line for line interrupt
 irq_en    in   1   line interrupt enable
 irq_ack   in   1   one-clk pulse; clears both interrupt requests
 pxl2_cen  out  1   2x pixel clock enable
 pxl_cen   out  1   pixel clock enable
 hdump     out  W   horizontal position
 vdump     out  W   vertical position
 vrender   out  W   line being rendered
 LHBL      out  1   horizontal blank, active low
 LVBL      out  1   vertical blank, active low
 HS        out  1   horizontal sync, active high
 VS        out  1   vertical sync, active high
 LHBL_dly  out  1   LHBL delayed DLY pixels
 LVBL_dly  out  1   LVBL delayed DLY pixels
 line_irqn out  1   raster interrupt request, active low
 vb_irqn   out  1   vblank interrupt request, active low

Function
REQ-007 Divider SHALL count 0..CEN_DIV-1 on every clk and wrap to 0.
REQ-008 pxl_cen SHALL be a registered one-clk pulse at divider=CEN_DIV-1; first pulse on the CEN_DIV-th rising edge after rstn release.
REQ-009 pxl2_cen SHALL pulse one clk at divider=CEN_DIV-1 and at divider=CEN_DIV/2-1.
REQ-010 Raw H counter SHALL advance only on clk edges where pxl_cen is high, wrapping HTOTAL-1 -> 0.
REQ-011 Raw V counter SHALL advance when H wraps, wrapping VTOTAL-1 -> 0.
REQ-012 LHBL SHALL be high iff raw H < HACTIVE.
REQ-013 HS SHALL be high iff HS_START <= raw H < HS_END.
REQ-014 LVBL SHALL be low iff raw V >= VB_START or raw V < VB_END.
REQ-015 VS SHALL be high iff VS_START <= raw V < VS_END.
REQ-016 LHBL, LVBL, HS, VS, hdump, vdump SHALL be registered and update in the same clk, always consistent with each other.
REQ-017 hdump/vdump SHALL equal raw H/V when flip=0, and bitwise inverse (W bits) when flip=1.
REQ-018 vrender SHALL equal (raw V + RENDER_AHEAD) mod VTOTAL, same flip rule, updating with vdump.
REQ-019 LHBL_dly/LVBL_dly SHALL equal LHBL/LVBL delayed exactly DLY pxl_cen pulses, via a shift register clocked by pxl_cen.
REQ-020 vb_irqn SHALL go low on the pxl_cen edge where LVBL falls.
REQ-021 line_irqn SHALL go low on the pxl_cen edge where raw H wraps to 0 and the new raw V equals irq_line with irq_en=1.
REQ-022 Each irqn, once low, SHALL stay low until irq_ack; irq_ack SHALL set both high next clk.
REQ-023 Simultaneous set and irq_ack in one clk SHALL leave the request asserted (set wins).
REQ-024 irq_en low SHALL block new line_irqn sets but not clear a pending one.
REQ-025 irq_line >= VTOTAL SHALL never fire line_irqn.
REQ-026 flip changes SHALL take effect at the next pxl_cen edge without disturbing raw counters.

Reset
REQ-027 rstn low SHALL asynchronously force divider, raw H, raw V, delay lines to 0.
REQ-028 During reset: pxl_cen=0, pxl2_cen=0, hdump=0, vdump=0, vrender=0, LHBL=0, LVBL=0, HS=0, VS=0, LHBL_dly=0, LVBL_dly=0, line_irqn=1, vb_irqn=1.
REQ-029 Reset asserted mid-frame SHALL restart timing from H=0,V=0 on release with no residual pulses.

Structure
REQ-030 Default timing constants (HTOTAL, HACTIVE, VTOTAL, blank/sync bounds) SHALL live in a shared package jtcontra_timing_pkg reused by the video top.
REQ-031 The enable divider SHALL be one sub-module, jtcontra_vtiming_cen, parametrised by CEN_DIV.

Verification
REQ-032 Release rstn, defaults -> first pxl_cen at clk 8, pxl2_cen at clks 4 and 8, period 8.
REQ-033 Run one frame -> H 0..383, V 0..263; LHBL low for 128 px per line; LVBL low for lines 240..263 and 0..15; HS 32 px; VS 3 lines.
REQ-034 flip=1 at H=100 -> hdump=~100 (411) next pxl_cen; raw counters unaffected; vrender=~(V+1).
REQ-035 irq_line=100, irq_en=1 -> line_irqn low at H=0,V=100; held until irq_ack; ack on same clk as set -> stays low.
REQ-036 V reaches 240 -> vb_irqn low; LVBL_dly falls 2 pxl_cen later; irq_line=300 -> line_irqn never fires.
REQ-037 rstn low mid-line (H=200,V=50) -> all outputs at reset values immediately; timing restarts at H=0,V=0.
